// File: rtl/unpack_normalize_float64.sv
// Multi-cycle float64 unpacker: splits an operand into sign/exponent/significand
// in roundAndPackFloat64 format, normalizing subnormals one bit per cycle.
module unpack_normalize_float64 #(
  parameter logic [31:0] FLAG_INVALID = 32'd16
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [31:0] float_exception_flag_i,
  output logic [31:0] float_exception_flag_o,
  output logic        float_exception_flag_o_ap_vld,
  output logic        zSign,
  output logic [11:0] zExp,
  output logic [63:0] zSig,
  output logic [2:0]  a_class
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    CLASSIFY = 4'b0010,
    NORM     = 4'b0100,
    DONE     = 4'b1000
  } state_t;

  state_t      state;
  logic [63:0] op;
  logic [52:0] sig;
  logic [5:0]  count;

  logic [10:0] exp_field;
  logic [51:0] frac;
  logic [5:0]  count_next;
  logic        is_snan;

  assign exp_field  = op[62:52];
  assign frac       = op[51:0];
  assign count_next = count + 6'd1;
  assign is_snan    = (state == CLASSIFY) && (exp_field == 11'h7FF) &&
                      (frac != 52'd0) && !frac[51];

  assign ap_idle  = (state == IDLE) && !ap_start;
  assign ap_done  = (state == DONE) || ap_idle;
  assign ap_ready = (state == DONE);

  assign float_exception_flag_o        = is_snan ? (float_exception_flag_i | FLAG_INVALID)
                                                 : float_exception_flag_i;
  assign float_exception_flag_o_ap_vld = is_snan;

  // Result registers are written only on the transition into DONE, so a
  // partially normalized significand is never visible.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      op      <= 64'd0;
      sig     <= 53'd0;
      count   <= 6'd0;
      zSign   <= 1'b0;
      zExp    <= 12'd0;
      zSig    <= 64'd0;
      a_class <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            op    <= a;
            state <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          if (exp_field == 11'd0) begin
            if (frac == 52'd0) begin
              zSign   <= op[63];
              zExp    <= 12'd0;
              zSig    <= 64'd0;
              a_class <= 3'd0;
              state   <= DONE;
            end else begin
              sig   <= {1'b0, frac};
              count <= 6'd0;
              state <= NORM;
            end
          end else if (exp_field != 11'h7FF) begin
            zSign   <= op[63];
            zExp    <= {1'b0, exp_field} - 12'd1;
            zSig    <= {2'b01, frac, 10'd0};
            a_class <= 3'd2;
            state   <= DONE;
          end else begin
            zSign   <= op[63];
            zExp    <= 12'h7FF;
            zSig    <= {2'b00, frac, 10'd0};
            a_class <= (frac == 52'd0) ? 3'd3 : (frac[51] ? 3'd4 : 3'd5);
            state   <= DONE;
          end
        end
        NORM: begin
          sig   <= {sig[51:0], 1'b0};
          count <= count_next;
          // The shift taken this cycle moves the leading one to bit 52.
          if (sig[51]) begin
            zSign   <= op[63];
            zExp    <= 12'd0 - {6'd0, count_next};
            zSig    <= {1'b0, sig[51:0], 11'd0};
            a_class <= 3'd1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_normalize_float64.sv
// Self-checking bench for unpack_normalize_float64: directed vector table,
// mid-normalization reset, and back-to-back starts with ap_start held high.
module tb_unpack_normalize_float64;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] a;
  logic [31:0] flag_i;
  logic [31:0] flag_o;
  logic        flag_vld;
  logic        zSign;
  logic [11:0] zExp;
  logic [63:0] zSig;
  logic [2:0]  a_class;

  int n_checks = 0;
  int n_fail   = 0;

  logic        prev_sign;
  logic [11:0] prev_exp;
  logic [63:0] prev_sig;
  logic [2:0]  prev_cls;

  typedef struct {
    logic [63:0] a;
    logic [31:0] flag;
    logic        sign;
    logic [11:0] exp;
    logic [63:0] sig;
    logic [2:0]  cls;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  unpack_normalize_float64 dut (
    .ap_clk                        (ap_clk),
    .ap_rst                        (ap_rst),
    .ap_start                      (ap_start),
    .ap_done                       (ap_done),
    .ap_idle                       (ap_idle),
    .ap_ready                      (ap_ready),
    .a                             (a),
    .float_exception_flag_i        (flag_i),
    .float_exception_flag_o        (flag_o),
    .float_exception_flag_o_ap_vld (flag_vld),
    .zSign                         (zSign),
    .zExp                          (zExp),
    .zSig                          (zSig),
    .a_class                       (a_class)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and follow it to DONE, checking handshake, flags,
  // latency and held-output behaviour along the way.
  task automatic applyStimulus(input vec_t v);
    int cycles;
    int vld_count;
    logic snan;
    snan = (v.cls == 3'd5);
    @(negedge ap_clk);
    a        = v.a;
    flag_i   = v.flag;
    ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start  = 1'b0;
    cycles    = 1;
    vld_count = 0;
    checkOutput("classify_idle", 64'(ap_idle), 64'd0);
    checkOutput("classify_done", 64'(ap_done), 64'd0);
    checkOutput("classify_flag_o", 64'(flag_o), 64'(snan ? (v.flag | 32'd16) : v.flag));
    checkOutput("hold_zExp", 64'(zExp), 64'(prev_exp));
    checkOutput("hold_zSig", zSig, prev_sig);
    checkOutput("hold_sign_class", 64'({prev_sign, prev_cls}), 64'({zSign, a_class}));
    while (!ap_ready && cycles < 80) begin
      if (flag_vld) vld_count++;
      @(negedge ap_clk);
      cycles++;
    end
    if (flag_vld) vld_count++;
    checkOutput("latency", 64'(cycles), 64'(v.lat));
    checkOutput("vld_cycles", 64'(vld_count), 64'(snan ? 1 : 0));
    checkOutput("done_strobe", 64'(ap_done), 64'd1);
    checkOutput("zSign", 64'(zSign), 64'(v.sign));
    checkOutput("zExp", 64'(zExp), 64'(v.exp));
    checkOutput("zSig", zSig, v.sig);
    checkOutput("a_class", 64'(a_class), 64'(v.cls));
    prev_sign = v.sign;
    prev_exp  = v.exp;
    prev_sig  = v.sig;
    prev_cls  = v.cls;
  endtask

  initial begin
    int ready_seen;
    int cycles;
    logic [63:0] cur;

    vecs[0]  = '{64'h3FF0000000000000, 32'h0, 1'b0, 12'h3FE, 64'h4000000000000000, 3'd2, 2};
    vecs[1]  = '{64'h0000000000000001, 32'h0, 1'b0, 12'hFCC, 64'h4000000000000000, 3'd1, 54};
    vecs[2]  = '{64'h0008000000000000, 32'h0, 1'b0, 12'hFFF, 64'h4000000000000000, 3'd1, 3};
    vecs[3]  = '{64'h7FF0000000000001, 32'h1, 1'b0, 12'h7FF, 64'h0000000000000400, 3'd5, 2};
    vecs[4]  = '{64'h7FF8000000000000, 32'h1, 1'b0, 12'h7FF, 64'h2000000000000000, 3'd4, 2};
    vecs[5]  = '{64'h8000000000000000, 32'h0, 1'b1, 12'h000, 64'h0000000000000000, 3'd0, 2};
    vecs[6]  = '{64'hFFF0000000000000, 32'h0, 1'b1, 12'h7FF, 64'h0000000000000000, 3'd3, 2};
    vecs[7]  = '{64'h000FFFFFFFFFFFFF, 32'h0, 1'b0, 12'hFFF, 64'h7FFFFFFFFFFFF800, 3'd1, 3};
    vecs[8]  = '{64'h0000000000000003, 32'h0, 1'b0, 12'hFCD, 64'h6000000000000000, 3'd1, 53};
    vecs[9]  = '{64'hC000000000000000, 32'h0, 1'b1, 12'h3FF, 64'h4000000000000000, 3'd2, 2};
    vecs[10] = '{64'h7FEFFFFFFFFFFFFF, 32'h0, 1'b0, 12'h7FD, 64'h7FFFFFFFFFFFFC00, 3'd2, 2};
    vecs[11] = '{64'h0010000000000000, 32'h0, 1'b0, 12'h000, 64'h4000000000000000, 3'd2, 2};

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    a        = 64'd0;
    flag_i   = 32'hA5;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checkOutput("rst_idle", 64'(ap_idle), 64'd1);
    checkOutput("rst_done", 64'(ap_done), 64'd1);
    checkOutput("rst_ready", 64'(ap_ready), 64'd0);
    checkOutput("rst_vld", 64'(flag_vld), 64'd0);
    checkOutput("rst_flag_pass", 64'(flag_o), 64'h0A5);
    checkOutput("rst_outputs", {zSig[59:0], zExp[0], zSign, a_class[1:0]} | 64'(zExp) | zSig, 64'd0);
    prev_sign = 1'b0;
    prev_exp  = 12'd0;
    prev_sig  = 64'd0;
    prev_cls  = 3'd0;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset in the middle of a long normalization.
    @(negedge ap_clk);
    a        = 64'h0000000000000001;
    ap_start = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (9) @(negedge ap_clk);
    checkOutput("midnorm_ready", 64'(ap_ready), 64'd0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    checkOutput("midrst_idle", 64'(ap_idle), 64'd1);
    checkOutput("midrst_zExp", 64'(zExp), 64'd0);
    checkOutput("midrst_zSig", zSig, 64'd0);
    checkOutput("midrst_sign_class", 64'({zSign, a_class}), 64'd0);
    checkOutput("midrst_ready", 64'(ap_ready), 64'd0);
    ready_seen = 0;
    repeat (60) begin
      @(negedge ap_clk);
      if (ap_ready) ready_seen++;
    end
    checkOutput("midrst_no_done", 64'(ready_seen), 64'd0);
    prev_sign = 1'b0;
    prev_exp  = 12'd0;
    prev_sig  = 64'd0;
    prev_cls  = 3'd0;
    applyStimulus(vecs[0]);

    // Back-to-back normals with ap_start held high; results must repack to a.
    @(negedge ap_clk);
    cur      = {1'($urandom), 11'($urandom_range(2046, 1)), 20'($urandom), 32'($urandom)};
    a        = cur;
    ap_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycles = 0;
      do begin
        @(negedge ap_clk);
        cycles++;
      end while (!ap_ready && cycles < 20);
      checkOutput("b2b_interval", 64'(cycles), 64'(k == 0 ? 2 : 3));
      checkOutput("b2b_repack", {zSign, 11'(zExp[10:0] + 11'd1), zSig[61:10]}, cur);
      checkOutput("b2b_sig_frame", 64'({zSig[63:62], zSig[9:0]}), 64'({2'b01, 10'd0}));
      cur = {1'($urandom), 11'($urandom_range(2046, 1)), 20'($urandom), 32'($urandom)};
      a   = cur;
    end
    ap_start = 1'b0;
    repeat (3) @(negedge ap_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unpack_normalize_float64.md
# unpack_normalize_float64

Multi-cycle IEEE-754 double unpacker for the DFSUB soft-float datapath. It accepts a packed float64 and produces the `zSign`/`zExp`/`zSig` triple in exactly the format consumed by `roundAndPackFloat64`:

- implicit bit at `zSig[62]`;
- 10 round bits at `zSig[9:0]`;
- `zExp` equal to the true biased exponent minus one.

Subnormal operands are normalized by a one-bit-per-cycle shift loop. Control uses the standard ap_ block-level handshake.

## Interface
Parameters:
- `FLAG_INVALID`, default 32'd16: exception bit OR-ed into the flag word for a signaling-NaN operand.

Ports:
- `ap_clk`  in  1  clock; all logic on rising edge.
- `ap_rst`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  request; sampled only in IDLE.
- `ap_done`  out  1  completion strobe.
- `ap_idle`  out  1  block idle.
- `ap_ready`  out  1  operand consumed / new start accepted next cycle.
- `a`  in  64  packed float64 operand; sampled in IDLE when `ap_start`=1.
- `float_exception_flag_i`  in  32  current flag word.
- `float_exception_flag_o`  out  32  updated flag word.
- `float_exception_flag_o_ap_vld`  out  1  write strobe for `float_exception_flag_o`.
- `zSign`  out  1  sign.
- `zExp`  out  12  two's-complement exponent.
- `zSig`  out  64  significand.
- `a_class`  out  3  operand class: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 qNaN, 5 sNaN.

## Operation
One-hot FSM with states IDLE, CLASSIFY, NORM, DONE.

- **IDLE**
  - If `ap_start`=1: latch `a` and go to CLASSIFY.
  - Otherwise stay in IDLE.
  - `ap_start` is ignored in every other state.
- **CLASSIFY** (let e=`a[62:52]`, f=`a[51:0]`)
  - e=0, f=0 → zero: `zExp`=0, `zSig`=0. Go to DONE.
  - e=0, f≠0 → subnormal: working sig = {12'd0, f}, count=0. Go to NORM.
  - 0<e<2047 → normal: `zExp`=e−1, `zSig`={2'b01, f, 10'd0}. Go to DONE.
  - e=2047 → inf/NaN: `zExp`=12'h7FF, `zSig`={2'b00, f, 10'd0}. Go to DONE.
    - f=0 → inf.
    - f[51]=1 → qNaN.
    - otherwise → sNaN: drive `float_exception_flag_o`=`float_exception_flag_i` | `FLAG_INVALID` with `_ap_vld`=1 for this cycle only.
  - `zSign`=`a[63]` in every case.
- **NORM**
  - Each cycle: sig <= sig<<1, count <= count+1.
  - When the pre-shift sig[51]=1, go to DONE.
  - On DONE: `zSig`={sig[52:0], 11'd0}>>1, so the leading one lands at bit 62; `zExp`=−count (12-bit two's complement).
  - count s = 52 − (index of msb of f), range 1..52.
- **DONE**
  - `ap_done`=1, `ap_ready`=1.
  - Go to IDLE unconditionally.
- Outside CLASSIFY-with-sNaN: `float_exception_flag_o`=`float_exception_flag_i` and `_ap_vld`=0.
- `zSign`, `zExp`, `zSig`, `a_class` are registered. They hold their last value until overwritten by the next operation.

## Timing
- Start accepted at cycle T (IDLE, `ap_start`=1).
- CLASSIFY occupies T+1; NORM occupies T+2..T+1+s; DONE occurs at T+2+s.
  - s=0 for all non-subnormal classes, so latency is 2.
  - Worst case s=52, latency 54.
- `ap_done` = DONE | (IDLE & !`ap_start`).
- `ap_idle` = IDLE & !`ap_start`.
- `ap_ready` = DONE.
- Back-to-back: the next start is accepted in the IDLE cycle immediately after DONE. Minimum issue interval is 3 cycles.
- Reset values:
  - FSM = IDLE.
  - `zSign`=0, `zExp`=0, `zSig`=0, `a_class`=0.
  - `_ap_vld`=0, `ap_ready`=0.
- `ap_rst` asserted in any state, including mid-NORM: next cycle FSM=IDLE, outputs at reset values, count and working sig cleared. A partially normalized result is never exposed.
- Output registers update only on entry to DONE. During CLASSIFY/NORM, outputs still show the previous result.

## Test plan
- `a`=0x3FF0000000000000 (1.0) → at T+2: `zSign`=0, `zExp`=0x3FE, `zSig`=0x4000000000000000, `a_class`=2; `_ap_vld` never high.
- `a`=0x0000000000000001 → s=52; DONE at T+54 with `zExp`=0xFCC, `zSig`=0x4000000000000000, `a_class`=1. Also check `a`=0x0008000000000000 → s=1, DONE at T+3, `zExp`=0xFFF, `zSig`=0x4000000000000000.
- `a`=0x7FF0000000000001 with flag_i=0x1 → at T+1: `float_exception_flag_o`=0x11 with `_ap_vld`=1 for exactly one cycle; at T+2: `zExp`=0x7FF, `zSig`=0x400, `a_class`=5. For `a`=0x7FF8000000000000: no vld, `a_class`=4.
- `a`=0x8000000000000000 → `zSign`=1, `zExp`=0, `zSig`=0, `a_class`=0. For `a`=0xFFF0000000000000: `a_class`=3, `zSign`=1.
- Start `a`=0x1, assert `ap_rst` at T+10 for one cycle → at T+11: IDLE, `ap_idle`=1 (with `ap_start`=0), all outputs 0. A subsequent start of 1.0 completes normally at +2.
- `ap_start` held high with 10k random normal operands → starts accepted every 3 cycles. Feeding (`zSign`, `zExp`, `zSig`) to `roundAndPackFloat64` returns the original `a` bit-exactly with no flags raised.
